ecc_scalar_mult_ctrl: RTL and testbench
=======================================

Name: ecc_scalar_mult_ctrl

Overview:
- Sequences left-to-right double-and-add scalar multiplication Q = k·P.
- Drives one shared external point-arithmetic unit through a req/done handshake. The unit wraps the point-addition datapath and the multiplicative inverse.
- Owns all point-at-infinity bookkeeping. The arithmetic unit only ever sees finite, valid operand pairs.
- Sits between the top-level ECC command interface and the point add/double datapath.

Parameters:
n, 231, field element width in bits (p, coordinates)
kw, 231, scalar width in bits

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request new multiplication; accepted only when busy=0
k  in  kw  scalar, latched on accepted start
p  in  n  field prime, latched on accepted start
px  in  n  base point x, latched
py  in  n  base point y, latched
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse, result valid
result_x  out  n  Q.x; held until next accepted start
result_y  out  n  Q.y; held
result_inf  out  1  Q is point at infinity; held
op_req  out  1  level; held until op_done
op_dbl  out  1  1 = double (x1,y1); 0 = add (x1,y1)+(x2,y2); stable while op_req
op_x1, op_y1, op_x2, op_y2  out  n  operands; stable while op_req
op_p  out  n  latched p
op_done  in  1  one-cycle pulse from unit; op_x3/op_y3/op_inf valid that cycle
op_x3, op_y3  in  n  unit result
op_inf  in  1  unit reports infinite result

Behaviour:
- Reset: state IDLE. busy, done, result_*, op_req, op_dbl, all op_* operands, and internal registers are 0. Reset mid-operation aborts immediately. An op_done arriving after reset is ignored.
- Internal registers: kreg (shift), cnt (bits remaining), acc_x, acc_y, acc_inf, base P.
- IDLE: start=1 latches inputs, goes to SCAN, busy=1. start while busy is ignored.
- SCAN: one bit per cycle.
  - k==0: go to DONE with result_inf=1, no ops issued.
  - Otherwise shift kreg left until MSB=1.
  - Then acc=P, acc_inf=0, cnt = number of bits below MSB.
  - Then go to NEXT.
- NEXT:
  - cnt==0: go to DONE.
  - Else decrement cnt, take next bit b (kreg shifted), go to DBL.
- DBL:
  - acc_inf=1: skip, no op, go to ADDCHK.
  - Else assert op_req, op_dbl=1, x1/y1=acc.
  - On op_done: acc ← (op_x3, op_y3), acc_inf ← op_inf, deassert op_req the same edge, go to ADDCHK.
- ADDCHK:
  - b=0: go to NEXT.
  - acc_inf=1: acc=P, acc_inf=0, go to NEXT (no op).
  - acc_x==px and acc_y==py: issue double of P (op_dbl=1).
  - acc_x==px and acc_y!=py: acc_inf=1, go to NEXT (no op; P + (−P)).
  - Otherwise issue add, op_dbl=0, x1/y1=acc, x2/y2=P. Capture result as in DBL, go to NEXT.
- DONE:
  - result_* ← acc/acc_inf.
  - done=1 for exactly one cycle, busy=0.
  - Return to IDLE; start is accepted the next cycle.
- op_req never asserts in IDLE, SCAN, NEXT, or DONE.
- op_done while op_req=0 is ignored.
- Unit latency is arbitrary (≥1 cycle); the controller waits indefinitely.
- Coordinates are assumed already reduced mod p. The controller performs no arithmetic beyond equality compares and counter decrements.

Test Plan:
(Curve y²=x³+2x+2 mod 17, P=(5,1), order 19, bench unit model with 3-cycle latency.)
- Reset mid-op: start k=5; assert reset during the second op → busy=0, op_req=0 next cycle; a stray op_done is ignored; a new start k=2 yields (6,3).
- k=0 → done with result_inf=1, zero op_req pulses. k=1 → (5,1), zero ops.
- k=3 → ops DBL, ADD → result (10,6), result_inf=0, busy deasserts the cycle done pulses.
- k=5 (101) → DBL, DBL, ADD → (9,16).
- k=19 (10011) → 4 DBL + 1 ADD issued; final 18P+P = (5,16)+(5,1) resolved internally → result_inf=1, exactly 5 op_req pulses.
- start asserted continuously during a k=5 run → ignored until DONE; a start on the cycle after done is accepted. Operands and op_dbl are stable throughout every op_req window.

Source files
------------

// File: rtl/ecc_scalar_mult_ctrl.sv
// ecc_scalar_mult_ctrl
// Sequences left-to-right double-and-add scalar multiplication Q = k*P over an
// external point-arithmetic unit (req/done handshake). All point-at-infinity
// bookkeeping is handled here, so the unit only ever sees finite operands.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, k, p, px, py        command; inputs latched when start is accepted (busy=0)
//   busy, done                 busy from cycle after accept until done; done is a 1-cycle pulse
//   result_x/y, result_inf     Q, held until overwritten by the next completion
//   op_req, op_dbl             level request to the unit; op_dbl=1 doubles (x1,y1)
//   op_x1/y1/x2/y2, op_p       operands and prime, stable while op_req is high
//   op_done, op_x3/y3, op_inf  unit completion pulse and result
module ecc_scalar_mult_ctrl #(
    parameter int unsigned N  = 231,
    parameter int unsigned KW = 231
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [KW-1:0] k,
    input  logic [N-1:0]  p,
    input  logic [N-1:0]  px,
    input  logic [N-1:0]  py,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result_x,
    output logic [N-1:0]  result_y,
    output logic          result_inf,
    output logic          op_req,
    output logic          op_dbl,
    output logic [N-1:0]  op_x1,
    output logic [N-1:0]  op_y1,
    output logic [N-1:0]  op_x2,
    output logic [N-1:0]  op_y2,
    output logic [N-1:0]  op_p,
    input  logic          op_done,
    input  logic [N-1:0]  op_x3,
    input  logic [N-1:0]  op_y3,
    input  logic          op_inf
);

    localparam int unsigned CW = (KW > 1) ? $clog2(KW) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_NEXT,
        S_DBL,
        S_ADDCHK,
        S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [KW-1:0]  kreg, kreg_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           bit_r, bit_nxt;
    logic [N-1:0]   acc_x, acc_x_nxt;
    logic [N-1:0]   acc_y, acc_y_nxt;
    logic           acc_inf, acc_inf_nxt;
    logic [N-1:0]   base_x, base_x_nxt;
    logic [N-1:0]   base_y, base_y_nxt;
    logic           busy_nxt, done_nxt;
    logic [N-1:0]   result_x_nxt, result_y_nxt;
    logic           result_inf_nxt;
    logic           op_req_nxt, op_dbl_nxt;
    logic [N-1:0]   op_x1_nxt, op_y1_nxt, op_x2_nxt, op_y2_nxt, op_p_nxt;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            kreg       <= '0;
            cnt        <= '0;
            bit_r      <= 1'b0;
            acc_x      <= '0;
            acc_y      <= '0;
            acc_inf    <= 1'b0;
            base_x     <= '0;
            base_y     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result_x   <= '0;
            result_y   <= '0;
            result_inf <= 1'b0;
            op_req     <= 1'b0;
            op_dbl     <= 1'b0;
            op_x1      <= '0;
            op_y1      <= '0;
            op_x2      <= '0;
            op_y2      <= '0;
            op_p       <= '0;
        end else begin
            state      <= state_nxt;
            kreg       <= kreg_nxt;
            cnt        <= cnt_nxt;
            bit_r      <= bit_nxt;
            acc_x      <= acc_x_nxt;
            acc_y      <= acc_y_nxt;
            acc_inf    <= acc_inf_nxt;
            base_x     <= base_x_nxt;
            base_y     <= base_y_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            result_x   <= result_x_nxt;
            result_y   <= result_y_nxt;
            result_inf <= result_inf_nxt;
            op_req     <= op_req_nxt;
            op_dbl     <= op_dbl_nxt;
            op_x1      <= op_x1_nxt;
            op_y1      <= op_y1_nxt;
            op_x2      <= op_x2_nxt;
            op_y2      <= op_y2_nxt;
            op_p       <= op_p_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        kreg_nxt       = kreg;
        cnt_nxt        = cnt;
        bit_nxt        = bit_r;
        acc_x_nxt      = acc_x;
        acc_y_nxt      = acc_y;
        acc_inf_nxt    = acc_inf;
        base_x_nxt     = base_x;
        base_y_nxt     = base_y;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        result_x_nxt   = result_x;
        result_y_nxt   = result_y;
        result_inf_nxt = result_inf;
        op_req_nxt     = op_req;
        op_dbl_nxt     = op_dbl;
        op_x1_nxt      = op_x1;
        op_y1_nxt      = op_y1;
        op_x2_nxt      = op_x2;
        op_y2_nxt      = op_y2;
        op_p_nxt       = op_p;

        case (state)
            S_IDLE: begin
                if (start) begin
                    kreg_nxt   = k;
                    op_p_nxt   = p;
                    base_x_nxt = px;
                    base_y_nxt = py;
                    cnt_nxt    = CW'(KW - 1);
                    busy_nxt   = 1'b1;
                    state_nxt  = S_SCAN;
                end
            end

            // Skip leading zeros; cnt ends as the number of bits below the MSB
            S_SCAN: begin
                if (kreg == '0) begin
                    result_x_nxt   = '0;
                    result_y_nxt   = '0;
                    result_inf_nxt = 1'b1;
                    done_nxt       = 1'b1;
                    busy_nxt       = 1'b0;
                    state_nxt      = S_DONE;
                end else if (kreg[KW-1]) begin
                    acc_x_nxt   = base_x;
                    acc_y_nxt   = base_y;
                    acc_inf_nxt = 1'b0;
                    kreg_nxt    = {kreg[KW-2:0], 1'b0};
                    state_nxt   = S_NEXT;
                end else begin
                    kreg_nxt = {kreg[KW-2:0], 1'b0};
                    cnt_nxt  = cnt - CW'(1);
                end
            end

            S_NEXT: begin
                if (cnt == '0) begin
                    result_x_nxt   = acc_x;
                    result_y_nxt   = acc_y;
                    result_inf_nxt = acc_inf;
                    done_nxt       = 1'b1;
                    busy_nxt       = 1'b0;
                    state_nxt      = S_DONE;
                end else begin
                    cnt_nxt   = cnt - CW'(1);
                    bit_nxt   = kreg[KW-1];
                    kreg_nxt  = {kreg[KW-2:0], 1'b0};
                    state_nxt = S_DBL;
                end
            end

            // Double the accumulator unless it is already at infinity
            S_DBL: begin
                if (op_req) begin
                    if (op_done) begin
                        acc_x_nxt   = op_x3;
                        acc_y_nxt   = op_y3;
                        acc_inf_nxt = op_inf;
                        op_req_nxt  = 1'b0;
                        state_nxt   = S_ADDCHK;
                    end
                end else if (acc_inf) begin
                    state_nxt = S_ADDCHK;
                end else begin
                    op_req_nxt = 1'b1;
                    op_dbl_nxt = 1'b1;
                    op_x1_nxt  = acc_x;
                    op_y1_nxt  = acc_y;
                end
            end

            // Conditional add of P; degenerate cases resolved without the unit
            S_ADDCHK: begin
                if (op_req) begin
                    if (op_done) begin
                        acc_x_nxt   = op_x3;
                        acc_y_nxt   = op_y3;
                        acc_inf_nxt = op_inf;
                        op_req_nxt  = 1'b0;
                        state_nxt   = S_NEXT;
                    end
                end else if (!bit_r) begin
                    state_nxt = S_NEXT;
                end else if (acc_inf) begin
                    acc_x_nxt   = base_x;
                    acc_y_nxt   = base_y;
                    acc_inf_nxt = 1'b0;
                    state_nxt   = S_NEXT;
                end else if (acc_x == base_x) begin
                    if (acc_y == base_y) begin
                        op_req_nxt = 1'b1;
                        op_dbl_nxt = 1'b1;
                        op_x1_nxt  = base_x;
                        op_y1_nxt  = base_y;
                    end else begin
                        // acc == -P, so acc + P is the point at infinity
                        acc_inf_nxt = 1'b1;
                        state_nxt   = S_NEXT;
                    end
                end else begin
                    op_req_nxt = 1'b1;
                    op_dbl_nxt = 1'b0;
                    op_x1_nxt  = acc_x;
                    op_y1_nxt  = acc_y;
                    op_x2_nxt  = base_x;
                    op_y2_nxt  = base_y;
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Testbench for ecc_scalar_mult_ctrl on curve y^2 = x^3 + 2x + 2 mod 17, P = (5,1).
// Point unit model with configurable latency; reference k*P by repeated addition.
module tb_ecc_scalar_mult_ctrl;

    localparam int unsigned N  = 231;
    localparam int unsigned KW = 231;
    localparam int CURVE_A = 2;
    localparam int PRIME   = 17;
    localparam int GX      = 5;
    localparam int GY      = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [KW-1:0] k = '0;
    logic [N-1:0]  p = '0, px = '0, py = '0;
    logic          busy, done;
    logic [N-1:0]  result_x, result_y;
    logic          result_inf;
    logic          op_req, op_dbl;
    logic [N-1:0]  op_x1, op_y1, op_x2, op_y2, op_p;
    logic          op_done = 1'b0;
    logic [N-1:0]  op_x3 = '0, op_y3 = '0;
    logic          op_inf = 1'b0;

    int errors = 0;
    int checks = 0;
    int lat = 3;
    bit inject_stray = 1'b0;
    int op_count = 0;

    ecc_scalar_mult_ctrl #(.N(N), .KW(KW)) dut (
        .clk(clk), .reset(reset), .start(start), .k(k), .p(p), .px(px), .py(py),
        .busy(busy), .done(done), .result_x(result_x), .result_y(result_y),
        .result_inf(result_inf), .op_req(op_req), .op_dbl(op_dbl),
        .op_x1(op_x1), .op_y1(op_y1), .op_x2(op_x2), .op_y2(op_y2), .op_p(op_p),
        .op_done(op_done), .op_x3(op_x3), .op_y3(op_y3), .op_inf(op_inf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int md(input int a, input int m);
        int r;
        r = a % m;
        if (r < 0) r += m;
        return r;
    endfunction

    function automatic int inv(input int a, input int m);
        for (int i = 1; i < m; i++) if (md(a * i, m) == 1) return i;
        return 0;
    endfunction

    // Affine point addition with full infinity handling
    function automatic void ec_add(input int m, input int ax, input int ay, input bit ainf,
                                   input int bx, input int by, input bit binf,
                                   output int rx, output int ry, output bit rinf);
        int lam;
        rx = bx; ry = by; rinf = binf;
        if (ainf) return;
        rx = ax; ry = ay; rinf = ainf;
        if (binf) return;
        rx = 0; ry = 0; rinf = 1'b0;
        if (ax == bx && md(ay + by, m) == 0) begin
            rinf = 1'b1;
            return;
        end
        if (ax == bx) lam = md((3 * ax * ax + CURVE_A) * inv(md(2 * ay, m), m), m);
        else          lam = md((by - ay) * inv(md(bx - ax, m), m), m);
        rx = md(lam * lam - ax - bx, m);
        ry = md(lam * (ax - rx) - ay, m);
    endfunction

    function automatic void ref_mult(input int kv, output int ex, output int ey, output bit einf);
        int ax, ay, tx, ty;
        bit ainf, tinf;
        ax = 0; ay = 0; ainf = 1'b1;
        for (int i = 0; i < kv; i++) begin
            ec_add(PRIME, ax, ay, ainf, GX, GY, 1'b0, tx, ty, tinf);
            ax = tx; ay = ty; ainf = tinf;
        end
        ex = ax; ey = ay; einf = ainf;
    endfunction

    // Point unit model: captures operands on op_req, answers after lat cycles
    bit           pend = 1'b0;
    int           wcnt = 0;
    logic         cap_dbl = 1'b0;
    logic [N-1:0] cx1 = '0, cy1 = '0, cx2 = '0, cy2 = '0;
    always @(posedge clk) begin
        int  rx, ry;
        bit  rinf;
        op_done <= 1'b0;
        if (reset) begin
            pend <= 1'b0;
        end else if (inject_stray) begin
            op_done <= 1'b1;
            op_x3   <= N'(7);
            op_y3   <= N'(7);
            op_inf  <= 1'b0;
        end else if (pend) begin
            chk("op_req_held", N'(op_req), N'(1));
            chk("op_dbl_stable", N'(op_dbl), N'(cap_dbl));
            chk("op_x1_stable", op_x1, cx1);
            chk("op_y1_stable", op_y1, cy1);
            if (!cap_dbl) begin
                chk("op_x2_stable", op_x2, cx2);
                chk("op_y2_stable", op_y2, cy2);
            end
            if (wcnt == 0) begin
                if (cap_dbl)
                    ec_add(int'(op_p), int'(cx1), int'(cy1), 1'b0, int'(cx1), int'(cy1), 1'b0, rx, ry, rinf);
                else
                    ec_add(int'(op_p), int'(cx1), int'(cy1), 1'b0, int'(cx2), int'(cy2), 1'b0, rx, ry, rinf);
                op_done <= 1'b1;
                op_x3   <= N'(rx);
                op_y3   <= N'(ry);
                op_inf  <= rinf;
                pend    <= 1'b0;
            end else begin
                wcnt <= wcnt - 1;
            end
        end else if (op_req && !op_done) begin
            pend     <= 1'b1;
            wcnt     <= lat - 1;
            cap_dbl  <= op_dbl;
            cx1      <= op_x1;
            cy1      <= op_y1;
            cx2      <= op_x2;
            cy2      <= op_y2;
            op_count <= op_count + 1;
        end
    end

    task automatic do_start(input int kv);
        @(negedge clk);
        k = KW'(kv); p = N'(PRIME); px = N'(GX); py = N'(GY); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string tag, input int kv);
        int ex, ey;
        bit einf;
        ref_mult(kv, ex, ey, einf);
        chk({tag, "_inf"}, N'(result_inf), N'(einf));
        if (!einf) begin
            chk({tag, "_x"}, result_x, N'(ex));
            chk({tag, "_y"}, result_y, N'(ey));
        end
    endtask

    task automatic run_check(input string tag, input int kv, input int exp_ops);
        bit ok;
        int ops0;
        ops0 = op_count;
        do_start(kv);
        chk({tag, "_busy"}, N'(busy), N'(1));
        wait_done(ok);
        chk({tag, "_timeout"}, N'(ok), N'(1));
        if (ok) begin
            chk({tag, "_busy_at_done"}, N'(busy), N'(0));
            check_result(tag, kv);
            if (exp_ops >= 0) chk({tag, "_ops"}, N'(op_count - ops0), N'(exp_ops));
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, N'(done), N'(0));
    endtask

    initial begin
        bit ok;
        int ops0;
        int kv;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", N'(busy), N'(0));
        chk("rst_done", N'(done), N'(0));
        chk("rst_op_req", N'(op_req), N'(0));
        chk("rst_result_x", result_x, N'(0));
        chk("rst_result_inf", N'(result_inf), N'(0));
        chk("rst_op_p", op_p, N'(0));
        chk("rst_op_x1", op_x1, N'(0));
        reset = 1'b0;

        // Reset during the second op of a k=5 run
        ops0 = op_count;
        do_start(5);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (op_count - ops0 >= 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("midop_second_op_seen", N'(ok), N'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midop_busy", N'(busy), N'(0));
        chk("midop_op_req", N'(op_req), N'(0));
        inject_stray = 1'b1;
        @(negedge clk);
        inject_stray = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_busy", N'(busy), N'(0));
        chk("stray_op_req", N'(op_req), N'(0));
        chk("stray_done", N'(done), N'(0));
        run_check("k2_after_reset", 2, 1);

        // Directed scalars
        run_check("k0", 0, 0);
        run_check("k1", 1, 0);
        run_check("k3", 3, 2);
        run_check("k5", 5, 3);
        run_check("k19", 19, 5);
        run_check("k38", 38, -1);

        // start held high through a k=5 run, with k changing underneath
        ops0 = op_count;
        @(negedge clk);
        k = KW'(5); p = N'(PRIME); px = N'(GX); py = N'(GY); start = 1'b1;
        @(negedge clk);
        chk("hold_busy", N'(busy), N'(1));
        k = KW'(3);
        wait_done(ok);
        chk("hold_timeout", N'(ok), N'(1));
        check_result("hold_k5", 5);
        chk("hold_ops", N'(op_count - ops0), N'(3));
        @(negedge clk);
        chk("hold_idle_busy", N'(busy), N'(0));
        @(negedge clk);
        chk("hold_reaccept_busy", N'(busy), N'(1));
        start = 1'b0;
        wait_done(ok);
        chk("hold2_timeout", N'(ok), N'(1));
        check_result("hold2_k3", 3);
        @(negedge clk);

        // Randomized scalars and unit latencies
        for (int i = 0; i < 10; i++) begin
            lat = int'($urandom_range(1, 4));
            kv  = int'($urandom_range(0, 63));
            run_check("rnd", kv, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
